// File: rtl/gelato_writeback_arbiter_pkg.sv
// gelato_writeback_pkg: shared writeback request type, source indices and bank mapping
package gelato_writeback_pkg;
  localparam int GW_BANK_NUM = 4;
  localparam int GW_WARP_W = 5;
  localparam int GW_REG_W = 5;
  localparam int GW_DATA_W = 1024;
  localparam int SRC_MEM = 0;
  localparam int SRC_COMPUTE = 1;
  localparam int SRC_TENSOR = 2;
  typedef struct packed {
    logic [GW_WARP_W-1:0] warp_num;
    logic [GW_REG_W-1:0]  reg_num;
    logic [GW_DATA_W-1:0] data;
  } wb_req_t;
  function automatic int bank_of(input logic [GW_WARP_W-1:0] warp_num, input logic [GW_REG_W-1:0] reg_num, input int bank_num);
    logic [7:0] sum;
    sum = 8'(warp_num) + 8'(reg_num);
    return int'({24'd0, sum} & 32'(bank_num - 1));
  endfunction
endpackage

// File: rtl/gelato_writeback_arbiter_if.sv
// gelato_writeback_if: source writeback requests in, per-bank register writes out
interface gelato_writeback_if #(
  parameter int SRC_NUM = 3,
  parameter int BANK_NUM = 4,
  parameter int WARP_W = 5,
  parameter int REG_W = 5,
  parameter int DATA_W = 1024
);
  logic [SRC_NUM-1:0]              src_valid;
  logic [SRC_NUM-1:0]              src_ready;
  logic [SRC_NUM-1:0][WARP_W-1:0]  src_warp_num;
  logic [SRC_NUM-1:0][REG_W-1:0]   src_reg_num;
  logic [SRC_NUM-1:0][DATA_W-1:0]  src_data;
  logic [BANK_NUM-1:0]             bank_write;
  logic [BANK_NUM-1:0][WARP_W-1:0] bank_warp_num;
  logic [BANK_NUM-1:0][REG_W-1:0]  bank_reg_num;
  logic [BANK_NUM-1:0][DATA_W-1:0] bank_data;
  modport master (
    output src_valid, src_warp_num, src_reg_num, src_data,
    input  src_ready, bank_write, bank_warp_num, bank_reg_num, bank_data
  );
  modport slave (
    input  src_valid, src_warp_num, src_reg_num, src_data,
    output src_ready, bank_write, bank_warp_num, bank_reg_num, bank_data
  );
endinterface

// File: rtl/gelato_writeback_arbiter_fifo.sv
// gelato_writeback_fifo: small synchronous FIFO buffering one source's writebacks
module gelato_writeback_fifo
  import gelato_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int PW = $clog2(DEPTH);
  wb_req_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  // storage is not reset; emptiness is tracked by cnt alone
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers and occupancy
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  assign head = mem[rp];
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/gelato_writeback_arbiter.sv
// gelato_writeback_arbiter: per-source FIFOs feeding per-bank round-robin register writes
module gelato_writeback_arbiter
  import gelato_writeback_pkg::*;
#(
  parameter int BANK_NUM = GW_BANK_NUM,
  parameter int SRC_NUM = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int WARP_W = GW_WARP_W,
  parameter int REG_W = GW_REG_W,
  parameter int DATA_W = GW_DATA_W
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  gelato_writeback_if.slave wb
);
  localparam int SIW = $clog2(SRC_NUM);
  logic [SRC_NUM-1:0] push, pop, full, empty;
  wb_req_t din [SRC_NUM];
  wb_req_t head [SRC_NUM];
  logic [BANK_NUM-1:0][SRC_NUM-1:0] gnt;
  logic [BANK_NUM-1:0] hit, write_q;
  logic [BANK_NUM-1:0][SIW-1:0] rr, sel;
  wb_req_t win [BANK_NUM];
  wb_req_t out_q [BANK_NUM];
  assign wb.src_ready = {SRC_NUM{rdy & ~rst}} & ~full;
  assign push = wb.src_valid & wb.src_ready;
  for (genvar s = 0; s < SRC_NUM; s++) begin : g_src
    assign din[s] = '{warp_num: GW_WARP_W'(wb.src_warp_num[s]), reg_num: GW_REG_W'(wb.src_reg_num[s]), data: GW_DATA_W'(wb.src_data[s])};
    gelato_writeback_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push[s]), .pop(pop[s]), .din(din[s]),
      .head(head[s]), .full(full[s]), .empty(empty[s])
    );
  end
  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    logic [SRC_NUM-1:0] req, g;
    logic h;
    logic [SIW-1:0] sl;
    // sources whose FIFO head targets this bank
    always_comb
      for (int s = 0; s < SRC_NUM; s++)
        req[s] = ~empty[s] && bank_of(head[s].warp_num, head[s].reg_num, BANK_NUM) == b;
    // first requester at or after the round-robin pointer, wrapping past the last source
    always_comb begin
      h = 1'b0;
      sl = '0;
      g = '0;
      for (int k = 0; k < SRC_NUM; k++) begin
        int idx;
        idx = int'(rr[b]) + k;
        idx = idx >= SRC_NUM ? idx - SRC_NUM : idx;
        if (!h && req[idx]) begin
          h = 1'b1;
          sl = SIW'(idx);
          g[idx] = 1'b1;
        end
      end
    end
    assign gnt[b] = g;
    assign hit[b] = h;
    assign sel[b] = sl;
    assign win[b] = head[sl];
    assign wb.bank_warp_num[b] = WARP_W'(out_q[b].warp_num);
    assign wb.bank_reg_num[b] = REG_W'(out_q[b].reg_num);
    assign wb.bank_data[b] = DATA_W'(out_q[b].data);
  end
  // a head pops when any bank grants it; a head maps to one bank so this is at most one pop
  always_comb begin
    pop = '0;
    for (int b = 0; b < BANK_NUM; b++) pop = pop | gnt[b];
    pop = pop & {SRC_NUM{rdy}};
  end
  // pointer advance and output capture; everything holds while rdy is low
  always_ff @(posedge clk)
    if (rst) begin
      rr <= '0;
      write_q <= '0;
      for (int b = 0; b < BANK_NUM; b++) out_q[b] <= '0;
    end else begin
      write_q <= hit & {BANK_NUM{rdy}};
      for (int b = 0; b < BANK_NUM; b++)
        if (rdy && hit[b]) begin
          rr[b] <= sel[b] == SIW'(SRC_NUM - 1) ? '0 : sel[b] + 1'b1;
          out_q[b] <= win[b];
        end
    end
  assign wb.bank_write = write_q;
endmodule
